// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the shared backing memory
// and the port arbiter that serialises their accesses.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch side
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              flush_i;
  logic [DATA_W-1:0] if_rdata_o;
  // Data side
  logic              dm_read_i;
  logic              dm_write_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  // Pipeline control
  logic              stall_o;
  logic              err_o;
  // Backing memory
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  // The arbiter itself
  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_rdata_o, dm_rdata_o, stall_o, err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // Pipeline stages plus memory, as seen from the environment
  modport master (
    output if_req_i, if_addr_i, flush_i,
    output dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_rdata_o, dm_rdata_o, stall_o, err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages: data access
// first, then fetch, one global stall, and a per-access ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DM_WAIT, IF_WAIT, DONE} state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flushed_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              err_q;

  logic              dm_req, fetch_ok, in_wait, acc_done, expired;
  logic [DATA_W-1:0] rdata_eff;
  logic              stall, mem_req, mem_we;
  logic              latch_dm, latch_if, dm_cap, if_cap;

  // NOTE: the async reset is in the sensitivity list; every register here,
  // data included, gets a reset value so outputs read 0 straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A timed-out access completes like an ack carrying zero data.
  always_comb begin
    dm_req    = bus.dm_read_i | bus.dm_write_i;
    fetch_ok  = bus.if_req_i & ~bus.flush_i;
    in_wait   = (state_q == DM_WAIT) || (state_q == IF_WAIT);
    acc_done  = in_wait & (bus.mem_ack_i | (cnt_q == CNT_LAST));
    expired   = acc_done & ~bus.mem_ack_i;
    rdata_eff = bus.mem_ack_i ? bus.mem_rdata_i : '0;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    latch_dm = 1'b0;
    latch_if = 1'b0;
    dm_cap   = 1'b0;
    if_cap   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = dm_req | fetch_ok;
        if (dm_req) begin
          latch_dm = 1'b1;
          state_d  = DM_WAIT;
        end else if (fetch_ok) begin
          latch_if = 1'b1;
          state_d  = IF_WAIT;
        end
      end
      DM_WAIT: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        if (acc_done) begin
          dm_cap = ~we_q;
          if (fetch_ok) begin
            latch_if = 1'b1;
            state_d  = IF_WAIT;
          end else begin
            state_d  = DONE;
          end
        end
      end
      IF_WAIT: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (acc_done) begin
          if_cap  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (latch_dm) begin
        addr_q  <= bus.dm_addr_i;
        wdata_q <= bus.dm_wdata_i;
        we_q    <= bus.dm_write_i;
      end else if (latch_if) begin
        addr_q  <= bus.if_addr_i;
      end

      if (latch_dm || latch_if)    cnt_q <= '0;
      else if (in_wait && !acc_done) cnt_q <= cnt_q + 1'b1;

      // A flush anywhere in IF_WAIT turns the fetched word into a NOP.
      if (latch_if)                                   flushed_q <= 1'b0;
      else if ((state_q == IF_WAIT) && bus.flush_i)   flushed_q <= 1'b1;

      if (dm_cap) dm_rdata_q <= rdata_eff;
      if (if_cap) if_rdata_q <= (flushed_q | bus.flush_i) ? '0 : rdata_eff;

      if (expired) err_q <= 1'b1;
    end
  end

  assign bus.stall_o     = stall & ~rst_i;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts memory accesses and per-transaction results, monitors compare them.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int T     = 16;
  localparam int NEVER = 1000;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
  } acc_t;

  typedef struct {
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] dm_rdata;
    logic          err;
    int            stalls;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  acc_t          acc_q[$];
  res_t          res_q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] bank_mem  [logic [AW-1:0]];
  logic [DW-1:0] exp_if = '0;
  logic [DW-1:0] exp_dm = '0;
  logic          exp_err = 1'b0;
  bit            stray_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0101;
  endfunction

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: acks each access after its scheduled latency, checks the request.
  initial begin : responder
    int   cnt;
    acc_t cur;
    cnt = 0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, lat: 0};
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
      if (rst) begin
        cnt = 0;
        continue;
      end
      if (bus.mem_req_o) begin
        if (cnt == 0) begin
          if (acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access: addr %h we %b", bus.mem_addr_o, bus.mem_we_o);
            cur = '{we: bus.mem_we_o, addr: bus.mem_addr_o, wdata: bus.mem_wdata_o, lat: 0};
          end else begin
            cur = acc_q.pop_front();
            check("mem_we", bus.mem_we_o, cur.we);
            check("mem_addr", bus.mem_addr_o, cur.addr);
            if (cur.we) check("mem_wdata", bus.mem_wdata_o, cur.wdata);
          end
        end
        if (cnt == cur.lat) begin
          if (cnt > 0) check("mem_addr_hold", bus.mem_addr_o, cur.addr);
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = bank_mem.exists(bus.mem_addr_o) ? bank_mem[bus.mem_addr_o]
                                                            : init_word(bus.mem_addr_o);
          if (bus.mem_we_o) bank_mem[bus.mem_addr_o] = bus.mem_wdata_o;
          cnt = 0;
        end else if (cnt == T - 1) begin
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (stray_en && ($urandom_range(0, 1) == 1)) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = $urandom;
        end
      end
    end
  end

  // Counts stall cycles and checks registered results on each release cycle.
  initial begin : result_mon
    int   stalls;
    res_t r;
    stalls = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalls = 0;
        continue;
      end
      if (bus.stall_o) begin
        stalls++;
      end else if (stalls > 0) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_release: stalls %0d", stalls);
        end else begin
          r = res_q.pop_front();
          check("stall_cycles", stalls, r.stalls);
          check("if_rdata", bus.if_rdata_o, r.if_rdata);
          check("dm_rdata", bus.dm_rdata_o, r.dm_rdata);
          check("err", bus.err_o, r.err);
          check("mem_req_release", bus.mem_req_o, 1'b0);
        end
        stalls = 0;
      end
    end
  end

  // dm_op: 0 none, 1 load, 2 store, 3 read+write (acts as store).
  // lat: ack on that WAIT cycle index (>= T means never). flush_at: IF_WAIT index or -1.
  task automatic do_txn(int dm_op, logic [AW-1:0] dm_addr, logic [DW-1:0] dm_wdata,
                        bit fetch, logic [AW-1:0] if_addr,
                        int lat_dm, int lat_if, int flush_at);
    int   dm_len, if_len, flush_cyc;
    bit   is_wr, to, done;
    res_t r;
    dm_len = 0; if_len = 0; flush_cyc = -1; done = 1'b0;
    is_wr  = (dm_op >= 2);
    if (dm_op != 0) begin
      acc_q.push_back('{we: is_wr, addr: dm_addr, wdata: dm_wdata, lat: lat_dm});
      to     = (lat_dm > T - 1);
      dm_len = to ? T : lat_dm + 1;
      if (to) exp_err = 1'b1;
      if (is_wr) begin
        if (!to) model_mem[dm_addr] = dm_wdata;
      end else begin
        exp_dm = to ? '0 : model_read(dm_addr);
      end
    end
    if (fetch) begin
      acc_q.push_back('{we: 1'b0, addr: if_addr, wdata: '0, lat: lat_if});
      to     = (lat_if > T - 1);
      if_len = to ? T : lat_if + 1;
      if (to) exp_err = 1'b1;
      exp_if = (to || flush_at >= 0) ? '0 : model_read(if_addr);
      if (flush_at >= 0) flush_cyc = 1 + dm_len + flush_at;
    end
    r = '{if_rdata: exp_if, dm_rdata: exp_dm, err: exp_err, stalls: 1 + dm_len + if_len};
    res_q.push_back(r);

    @(negedge clk);
    bus.dm_read_i  = (dm_op == 1) || (dm_op == 3);
    bus.dm_write_i = (dm_op >= 2);
    bus.dm_addr_i  = dm_addr;
    bus.dm_wdata_i = dm_wdata;
    bus.if_req_i   = fetch;
    bus.if_addr_i  = if_addr;
    bus.flush_i    = 1'b0;
    for (int cyc = 1; cyc <= 3 * T + 8; cyc++) begin
      @(negedge clk);
      if (!bus.stall_o) begin
        done = 1'b1;
        break;
      end
      bus.flush_i = (cyc == flush_cyc);
    end
    bus.dm_read_i  = 1'b0;
    bus.dm_write_i = 1'b0;
    bus.if_req_i   = 1'b0;
    bus.flush_i    = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL txn_timeout: stall never released");
    end
  endtask

  // Fetch cancelled in IDLE by a same-cycle flush: no stall, no access.
  task automatic cancelled_fetch();
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0080;
    bus.flush_i   = 1'b1;
    #2 check("stall_cancelled_fetch", bus.stall_o, 1'b0);
    @(negedge clk);
    bus.if_req_i = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    acc_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: '0, lat: NEVER});
    bus.dm_read_i = 1'b1;
    bus.dm_addr_i = 32'h0000_0300;
    repeat (3) @(negedge clk);
    check("mem_req_before_rst", bus.mem_req_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_stall", bus.stall_o, 1'b0);
    check("rst_mem_we", bus.mem_we_o, 1'b0);
    check("rst_mem_addr", bus.mem_addr_o, '0);
    check("rst_mem_wdata", bus.mem_wdata_o, '0);
    check("rst_if_rdata", bus.if_rdata_o, '0);
    check("rst_dm_rdata", bus.dm_rdata_o, '0);
    check("rst_err", bus.err_o, 1'b0);
    bus.dm_read_i = 1'b0;
    exp_if = '0; exp_dm = '0; exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_txn(bit allow_to);
    int            dm_op, lat_dm, lat_if, flush_at, lim;
    bit            fetch;
    logic [AW-1:0] a_dm, a_if;
    dm_op    = $urandom_range(0, 3);
    fetch    = ($urandom_range(0, 2) != 0) || (dm_op == 0);
    a_dm     = 32'h0000_0100 + 32'($urandom_range(0, 15) << 2);
    a_if     = 32'h0000_0100 + 32'($urandom_range(0, 15) << 2);
    lat_dm   = $urandom_range(0, 4);
    lat_if   = $urandom_range(0, 4);
    if (allow_to) begin
      if ($urandom_range(0, 7) == 0) lat_dm = NEVER;
      if ($urandom_range(0, 7) == 0) lat_if = NEVER;
      if ($urandom_range(0, 9) == 0) lat_if = T - 1;
    end
    flush_at = -1;
    if (fetch && ($urandom_range(0, 3) == 0)) begin
      lim      = (lat_if > T - 1) ? T - 1 : lat_if;
      flush_at = $urandom_range(0, lim);
    end
    stray_en = ($urandom_range(0, 1) == 1);
    do_txn(dm_op, a_dm, $urandom, fetch, a_if, lat_dm, lat_if, flush_at);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if ($urandom_range(0, 5) == 0) cancelled_fetch();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    bus.if_req_i = 1'b1; bus.if_addr_i = '0; bus.flush_i = 1'b0;
    bus.dm_read_i = 1'b1; bus.dm_write_i = 1'b0;
    bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    model_mem[32'h40] = 32'h8C01_0004; bank_mem[32'h40] = 32'h8C01_0004;
    model_mem[32'h48] = 32'h1234_5678; bank_mem[32'h48] = 32'h1234_5678;

    #7;
    check("reset_stall_forced_low", bus.stall_o, 1'b0);
    check("reset_mem_req", bus.mem_req_o, 1'b0);
    check("reset_if_rdata", bus.if_rdata_o, '0);
    check("reset_dm_rdata", bus.dm_rdata_o, '0);
    check("reset_err", bus.err_o, 1'b0);
    bus.if_req_i = 1'b0; bus.dm_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    stray_en = 1'b1;
    do_txn(0, '0, '0, 1'b1, 32'h40, 0, 0, -1);
    do_txn(2, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h44, 0, 0, -1);
    do_txn(0, '0, '0, 1'b1, 32'h48, 0, 3, 1);
    cancelled_fetch();
    reset_mid();
    do_txn(0, '0, '0, 1'b1, 32'h40, 0, 0, -1);
    do_txn(3, 32'h104, 32'hCAFE_F00D, 1'b1, 32'h104, 1, 2, -1);
    do_txn(1, 32'h104, '0, 1'b0, '0, T - 1, 0, -1);

    for (int i = 0; i < 40; i++) random_txn(1'b0);

    do_txn(1, 32'h200, '0, 1'b0, '0, NEVER, 0, -1);
    do_txn(0, '0, '0, 1'b1, 32'h40, 2, 0, -1);

    for (int i = 0; i < 25; i++) random_txn(1'b1);

    repeat (4) @(negedge clk);
    check("results_drained", res_q.size(), 0);
    check("accesses_drained", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
